alu_share_arbiter: RTL and testbench

Round-robin arbiter that shares one matrix ALU between NUM_REQ instruction issuers (exe-style decode engines). Each issuer presents a decoded 19-bit instruction with a request. The arbiter grants one issuer at a time, drives the ALU operand bus with a single-cycle en_alu pulse, waits for ALU done, and returns a completion pulse to the owner. It sits between the issuers and the single ALU instance, and also provides a watchdog and brick filtering.

---
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one matrix ALU between NUM_REQ issuers,
// with a WAIT watchdog and all-zero (brick) instruction filtering.
module alu_share_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 64,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*19-1:0] instr,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  req_err,
  output logic [2:0]            alu_op,
  output logic [3:0]            alu_s1,
  output logic [7:0]            alu_s2,
  output logic [3:0]            alu_dest,
  output logic                  en_alu,
  input  logic                  alu_done,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       cnt;

  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] idx;
  logic [18:0]      win_instr;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(NUM_REQ - 1)) return '0;
    return x + 1'b1;
  endfunction

  // scan downward so the smallest offset from rr_ptr wins
  always_comb begin
    win = rr_ptr;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) win = idx;
    end
    win_instr = instr[19*int'(win) +: 19];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      req_done    <= '0;
      req_err     <= 1'b0;
      en_alu      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      alu_op      <= '0;
      alu_s1      <= '0;
      alu_s2      <= '0;
      alu_dest    <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            owner <= win;
            busy  <= 1'b1;
            if (win_instr == '0) begin
              req_done <= NUM_REQ'(1) << win;
              req_err  <= 1'b0;
              rr_ptr   <= nxt(win);
              state    <= GAP;
            end else begin
              alu_op   <= win_instr[18:16];
              alu_s1   <= win_instr[15:12];
              alu_s2   <= win_instr[11:4];
              alu_dest <= win_instr[3:0];
              gnt      <= NUM_REQ'(1) << win;
              en_alu   <= 1'b1;
              cnt      <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          en_alu <= 1'b0;
          cnt    <= cnt + 8'd1;
          // a late alu_done in the timeout cycle still counts as success
          if (alu_done || cnt == CNT_LAST) begin
            gnt      <= '0;
            req_done <= NUM_REQ'(1) << owner;
            req_err  <= ~alu_done;
            if (!alu_done) timeout_err <= 1'b1;
            rr_ptr   <= nxt(owner);
            state    <= GAP;
          end
        end
        GAP: begin
          req_done <= '0;
          req_err  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter against a
// transaction-level round-robin model.
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*19-1:0] instr;
  logic [N-1:0]  gnt;
  logic [N-1:0]  req_done;
  logic          req_err;
  logic [2:0]    alu_op;
  logic [3:0]    alu_s1;
  logic [7:0]    alu_s2;
  logic [3:0]    alu_dest;
  logic          en_alu;
  logic          alu_done;
  logic [1:0]    owner;
  logic          busy;
  logic          timeout_err;

  alu_share_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .instr(instr),
    .gnt(gnt), .req_done(req_done), .req_err(req_err),
    .alu_op(alu_op), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_dest(alu_dest), .en_alu(en_alu), .alu_done(alu_done),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [18:0] ins [N];
  int  rr = 0;
  bit  sticky = 0;
  bit  in_gap = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", req_done, 0);
      chk("idle_en", en_alu, 0);
      chk("idle_gnt", gnt, 0);
      in_gap = 0;
    end
  endtask

  // d = WAIT cycles before alu_done is driven high
  task automatic run_txn(input logic [N-1:0] r, input int d);
    int w;
    int n;
    logic [18:0] wi;
    bit err;
    req   = r;
    instr = {ins[3], ins[2], ins[1], ins[0]};
    w  = pick(r);
    wi = ins[w];
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en_alu && req_done == '0 && n < 4);
    chk("latency", n, in_gap ? 2 : 1);
    chk("owner", owner, w);
    chk("busy", busy, 1);
    if (wi == '0) begin
      chk("brick_en", en_alu, 0);
      chk("brick_gnt", gnt, 0);
      chk("brick_done", req_done, 1 << w);
      chk("brick_err", req_err, 0);
    end else begin
      chk("en_alu", en_alu, 1);
      chk("gnt", gnt, 1 << w);
      chk("op", alu_op, wi[18:16]);
      chk("s1", alu_s1, wi[15:12]);
      chk("s2", alu_s2, wi[11:4]);
      chk("dest", alu_dest, wi[3:0]);
      chk("wait_done", req_done, 0);
      err = (d >= TO);
      for (int k = 1; k <= TO + 2; k++) begin
        alu_done = (k == d + 1);
        instr[19*w +: 19] = 19'($urandom);
        if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
        @(negedge clk);
        if (k == d + 1 || k == TO) break;
        chk("w_en", en_alu, 0);
        chk("w_gnt", gnt, 1 << w);
        chk("w_1hot", $onehot0(gnt), 1);
        chk("w_busy", busy, 1);
        chk("w_done", req_done, 0);
        chk("w_fields", {alu_op, alu_s1, alu_s2, alu_dest}, wi);
      end
      chk("done", req_done, 1 << w);
      chk("req_err", req_err, err);
      chk("gap_gnt", gnt, 0);
      chk("gap_en", en_alu, 0);
      chk("gap_busy", busy, 1);
      if (err) sticky = 1;
    end
    chk("timeout_err", timeout_err, sticky);
    rr       = (w + 1) % N;
    in_gap   = 1;
    alu_done = 1'($urandom);
    req      = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req = '0;
    alu_done = 1'b0;
    for (int i = 0; i < N; i++) ins[i] = 19'h1;
    instr = '0;
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_en", en_alu, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_owner", owner, 0);
    chk("rst_fields", {alu_op, alu_s1, alu_s2, alu_dest}, 0);
    rst = 1'b0;
    idle(2);

    ins[0] = 19'b0010000000000010010;
    run_txn(4'b0001, 3);
    idle(1);

    for (int i = 0; i < N; i++) ins[i] = 19'($urandom) | 19'h1;
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0);

    run_txn(4'b1010, 0);
    run_txn(4'b1010, 1);
    run_txn(4'b0010, 0);

    ins[2] = '0;
    run_txn(4'b0100, 0);
    run_txn(4'b1100, 2);
    ins[2] = 19'h4321;

    run_txn(4'b0001, 20);
    run_txn(4'b0010, 0);
    run_txn(4'b0100, TO - 1);
    idle(1);

    ins[0] = 19'h12345;
    instr  = {ins[3], ins[2], ins[1], ins[0]};
    req = 4'b0001;
    alu_done = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en_alu && n < 4);
    chk("pre_rst_en", en_alu, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_en", en_alu, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", req_done, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_owner", owner, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    sticky = 0;
    in_gap = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", req_done, 0);
    end
    run_txn(4'b0100, 1);
    idle(1);
    run_txn(4'b1010, 0);

    for (int t = 0; t < 150; t++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++)
        ins[i] = ($urandom_range(0, 5) == 0) ? 19'h0 : 19'($urandom);
      r = 4'($urandom_range(1, 15));
      run_txn(r, $urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
